stopwatch_controller: RTL
=========================

Name: stopwatch_controller

Overview:
- Control and timekeeping core of the digital stopwatch.
- Takes three push-buttons (start/stop, clear, lap) and runs a 4-digit BCD count in the format SS.hh (00.00–99.99 s).
- Drives the 16-bit digit vector consumed by the existing hex-to-7-segment / time-multiplexed display path, in place of the switch bank.
- Sequences the display content: live count or a frozen lap snapshot.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (one tick = 0.01 s). DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2.
- DB_CYCLES, 1000000, number of consecutive stable cycles a synchronized button must hold before its debounced level changes.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_start  input  1  raw start/stop button, asynchronous, active-high.
- btn_clear  input  1  raw clear button, asynchronous, active-high.
- btn_lap  input  1  raw lap button, asynchronous, active-high.
- digits  output  16  BCD digits {S1,S0,h1,h0}, [15:12] = tens of seconds; feeds the display path.
- running  output  1  high in RUN.
- lap_active  output  1  high while digits shows the frozen snapshot.
- overflow  output  1  sticky flag, set on wrap 99.99 -> 00.00.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; count = 0000; snapshot = 0000; digits = 16'h0000; prescaler = 0; running = 0; lap_active = 0; overflow = 0; synchronizers, debouncers and edge registers all 0.
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debouncer: a counter reloads on any mismatch between the synced input and the debounced level. The debounced level flips after DB_CYCLES consecutive mismatching cycles.
  - Rising-edge detector produces a 1-cycle pulse (start_p, clear_p, lap_p).
  - Falling edges produce nothing.
- State machine, registered, acting on pulses:
  - IDLE:
    - start_p -> RUN; prescaler cleared.
    - clear_p and lap_p ignored.
  - RUN:
    - start_p -> PAUSE.
    - lap_p toggles lap_active; on 0->1, snapshot <= count in the same edge.
    - clear_p ignored.
  - PAUSE:
    - start_p -> RUN; prescaler and count retained.
    - clear_p -> IDLE with count = 0, lap_active = 0, overflow = 0.
    - lap_p: if lap_active = 1, clears it; otherwise ignored.
  - Simultaneous pulses:
    - PAUSE: clear_p beats start_p.
    - RUN and IDLE: start_p acts, clear_p is ignored.
    - RUN with start_p and lap_p together: both act; the snapshot takes the pre-edge count.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds in PAUSE.
  - tick is asserted when prescaler = DIV-1 while in RUN; the prescaler then wraps to 0.
  - First tick after leaving IDLE arrives DIV cycles after entering RUN.
  - If start_p (RUN->PAUSE) and tick coincide, the tick is applied.
- Count, on tick:
  - h0 increments 0..9; a carry ripples h0 -> h1 -> S0 -> S1 in the same cycle.
  - Each digit wraps 9 -> 0; no value outside 0–9 is ever produced.
  - 99.99 + tick -> 00.00, overflow <= 1; counting continues.
- digits is registered: lap_active ? snapshot : count. It updates one cycle after the count/snapshot/lap_active change.
- running = (state == RUN), registered together with the state.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), DB_CYCLES=4.
1. Reset mid-RUN at count 12.34 -> all outputs 0 asynchronously while rst_n is low; a button already held at release does not trigger until it is released and pressed again.
2. Debounce: pulse btn_start for 3 cycles -> no state change. Hold it 10 cycles -> running = 1 exactly once. A 2-cycle glitch while held -> no second edge.
3. Start, then wait 250 ticks (2500 cycles) -> digits = 16'h0250. start_p -> PAUSE; after 100 further cycles digits is still 16'h0250. Start again -> resumes with no lost prescaler phase.
4. Lap in RUN at 03.07 -> digits freezes at 16'h0307 while the count continues. Second lap_p 50 ticks later -> digits = 16'h0357 live.
5. Run from 99.95 for 6 ticks -> digits = 16'h0001, overflow = 1. Pause then clear -> IDLE, digits = 16'h0000, overflow = 0.
6. In PAUSE press start and clear in the same cycle -> IDLE with count 0. In RUN press clear alone -> ignored, count keeps advancing.

Source files
------------

// File: rtl/stopwatch_controller.sv
// Stopwatch core: conditions the start/clear/lap buttons, sequences IDLE/RUN/PAUSE
// and keeps a 4-digit BCD SS.hh count with a frozen lap view and a sticky overflow.
module stopwatch_controller #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    db_level;
    logic [2:0]    edge_q;
    logic [2:0]    armed;
    logic [1:0]    primed;
    logic [DW-1:0] db_cnt [3];
    logic [2:0]    pulse;
    logic          start_p;
    logic          clear_p;
    logic          lap_p;

    assign raw = {btn_lap, btn_clear, btn_start};

    // A button only arms once it has been seen released after reset, so a key
    // held through reset release cannot fire until it is pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            edge_q   <= '0;
            armed    <= '0;
            primed   <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            edge_q <= db_level;
            primed <= {primed[0], 1'b1};
            for (int i = 0; i < 3; i++) begin
                armed[i] <= armed[i] | (primed[1] & ~sync2[i]);
                if (sync2[i] != db_level[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        db_level[i] <= ~db_level[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign pulse   = db_level & ~edge_q & armed;
    assign start_p = pulse[0];
    assign clear_p = pulse[1];
    assign lap_p   = pulse[2];

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] >= 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [15:0]   count;
    logic [15:0]   count_next;
    logic [15:0]   snapshot;
    logic [15:0]   snap_next;
    logic          lap_next;
    logic          ovf_next;
    logic          tick;

    assign tick = (state == RUN) && (presc == PRESC_MAX);

    always_comb begin
        state_next = state;
        presc_next = presc;
        count_next = count;
        snap_next  = snapshot;
        lap_next   = lap_active;
        ovf_next   = overflow;
        if (tick) begin
            count_next = bcd_inc(count);
            if (count == 16'h9999) begin
                ovf_next = 1'b1;
            end
        end
        case (state)
            IDLE: begin
                if (start_p) begin
                    state_next = RUN;
                    presc_next = '0;
                end
            end
            RUN: begin
                presc_next = tick ? '0 : presc + PW'(1);
                if (start_p) begin
                    state_next = PAUSE;
                end
                // Snapshot takes the pre-edge count even when a tick lands on the same edge.
                if (lap_p) begin
                    lap_next = ~lap_active;
                    if (!lap_active) begin
                        snap_next = count;
                    end
                end
            end
            PAUSE: begin
                if (clear_p) begin
                    state_next = IDLE;
                    presc_next = '0;
                    count_next = '0;
                    lap_next   = 1'b0;
                    ovf_next   = 1'b0;
                end else begin
                    if (start_p) begin
                        state_next = RUN;
                    end
                    if (lap_p) begin
                        lap_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            count      <= '0;
            snapshot   <= '0;
            lap_active <= 1'b0;
            overflow   <= 1'b0;
            digits     <= '0;
            running    <= 1'b0;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            count      <= count_next;
            snapshot   <= snap_next;
            lap_active <= lap_next;
            overflow   <= ovf_next;
            digits     <= lap_active ? snapshot : count;
            running    <= (state_next == RUN);
        end
    end

endmodule
